// File: rtl/fpm_pkg.sv
// Shared types and constants for the flash period meter.
package fpm_pkg;

  // Default counter width and loss-of-flash timeout.
  localparam int CNT_W_DEF   = 16;
  localparam int TIMEOUT_DEF = 10000;

  // Duty-cycle result width and percentage scale.
  localparam int DUTY_W    = 7;
  localparam int PCT_SCALE = 100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MEAS = 2'd1,
    ST_LOST = 2'd2
  } fpm_state_e;

endpackage

// File: rtl/fpm_serial_div.sv
// Serial restoring divider: one quotient bit per clock, DVD_W cycles per
// divide. The quotient is published together with a one-cycle done strobe
// and holds until the next completion.
module fpm_serial_div #(
  parameter int DVD_W = 23,
  parameter int DVS_W = 16,
  parameter int Q_W   = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [DVD_W-1:0] dividend,
  input  logic [DVS_W-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [Q_W-1:0]   quotient
);

  localparam int CW = $clog2(DVD_W + 1);

  logic [CW-1:0]    step_cnt;
  logic [DVD_W-1:0] dvd_p0;
  logic [DVS_W-1:0] dvs_p0;
  logic [DVS_W-1:0] rem_p0;
  logic [DVS_W:0]   rem_sh;
  logic [DVS_W:0]   diff;
  logic             qbit;

  // Trial subtraction of the divisor from the shifted partial remainder.
  always_comb begin
    rem_sh = {rem_p0, dvd_p0[DVD_W-1]};
    diff   = rem_sh - {1'b0, dvs_p0};
    qbit   = ~diff[DVS_W];
  end

  // Control: busy window, step counter, done strobe and published result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      step_cnt <= '0;
      quotient <= '0;
    end else begin
      done <= 1'b0;
      if (start && !busy) begin
        busy     <= 1'b1;
        step_cnt <= CW'(DVD_W);
      end else if (busy) begin
        step_cnt <= step_cnt - 1'b1;
        if (step_cnt == CW'(1)) begin
          busy     <= 1'b0;
          done     <= 1'b1;
          quotient <= Q_W'({dvd_p0[DVD_W-2:0], qbit});
        end
      end
    end
  end

  // Datapath: dividend register doubles as quotient shift register.
  always_ff @(posedge clk) begin
    if (start && !busy) begin
      dvd_p0 <= dividend;
      dvs_p0 <= divisor;
      rem_p0 <= '0;
    end else if (busy) begin
      rem_p0 <= qbit ? diff[DVS_W-1:0] : rem_sh[DVS_W-1:0];
      dvd_p0 <= {dvd_p0[DVD_W-2:0], qbit};
    end
  end

endmodule

// File: rtl/flash_period_meter.sv
// Flash period meter: measures period and high time of the divider flash
// output in clk cycles, strobes each complete period and flags loss of
// flashing. Optional duty-cycle divider enabled by defining FPM_DUTY_EN.
module flash_period_meter
  import fpm_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              f_in,
  output logic [CNT_W-1:0]  period,
  output logic [CNT_W-1:0]  high_time,
  output logic              meas_valid,
  output logic              lost,
  output logic [DUTY_W-1:0] duty_pct,
  output logic              duty_valid
);

  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  logic       f_p0, f_p1, f_p2;
  logic       rise;
  logic [CNT_W-1:0] per_cnt;
  logic [CNT_W-1:0] hi_cnt;
  fpm_state_e state_q, state_d;
  logic       capture;
  logic       lost_d;

  // Two-flop synchronizer for the asynchronous flash input plus an edge-detect delay flop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      f_p0 <= 1'b0;
      f_p1 <= 1'b0;
      f_p2 <= 1'b0;
    end else begin
      f_p0 <= f_in;
      f_p1 <= f_p0;
      f_p2 <= f_p1;
    end
  end

  // ---- stage boundary: synchronized level f_p1, previous level f_p2 ----
  assign rise = f_p1 & ~f_p2;

  // Period and high-time counters, restarted by each rising edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      per_cnt <= '0;
      hi_cnt  <= '0;
    end else if (rise) begin
      per_cnt <= '0;
      hi_cnt  <= CNT_W'(1);
    end else begin
      per_cnt <= sat_inc(per_cnt);
      if (f_p1) hi_cnt <= sat_inc(hi_cnt);
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next state; a rise on the timeout cycle takes priority over the timeout.
  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    lost_d  = lost;
    unique case (state_q)
      ST_IDLE: if (rise) state_d = ST_MEAS;
      ST_MEAS: begin
        if (rise) begin
          capture = 1'b1;
        end else if (per_cnt == TO_LAST) begin
          state_d = ST_LOST;
          lost_d  = 1'b1;
        end
      end
      ST_LOST: begin
        if (rise) begin
          state_d = ST_MEAS;
          lost_d  = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ---- stage boundary: registered measurement outputs ----
  // Capture results on each complete period; hold them otherwise.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      period     <= '0;
      high_time  <= '0;
      meas_valid <= 1'b0;
      lost       <= 1'b0;
    end else begin
      meas_valid <= capture;
      lost       <= lost_d;
      if (capture) begin
        period    <= sat_inc(per_cnt);
        high_time <= hi_cnt;
      end
    end
  end

`ifdef FPM_DUTY_EN
  localparam int DIV_W = CNT_W + DUTY_W;

  logic             div_busy;
  logic             div_done;
  logic [DUTY_W-1:0] div_q;
  logic [DIV_W-1:0] dividend;

  // Strobes arriving while a divide is in flight are dropped.
  assign dividend = DIV_W'(high_time) * DIV_W'(PCT_SCALE);

  fpm_serial_div #(
    .DVD_W (DIV_W),
    .DVS_W (CNT_W),
    .Q_W   (DUTY_W)
  ) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (meas_valid & ~div_busy),
    .dividend (dividend),
    .divisor  (period),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (div_q)
  );

  assign duty_pct   = div_q;
  assign duty_valid = div_done;
`else
  assign duty_pct   = '0;
  assign duty_valid = 1'b0;
`endif

endmodule

// File: tb/tb_flash_period_meter.sv
// Self-checking bench for flash_period_meter: directed scenarios plus random
// flash segments, checked every cycle against a behavioural model.
module tb_flash_period_meter;

  localparam int CNT_W   = 16;
  localparam int TIMEOUT = 10000;
  localparam int CMAX    = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             f_in;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             meas_valid;
  logic             lost;
  logic [6:0]       duty_pct;
  logic             duty_valid;

  flash_period_meter #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .f_in       (f_in),
    .period     (period),
    .high_time  (high_time),
    .meas_valid (meas_valid),
    .lost       (lost),
    .duty_pct   (duty_pct),
    .duty_valid (duty_valid)
  );

  always #10 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int mv_seen = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Tracks f_in samples, rise edge indices and high cycles since the last rise.
  int  e = 0;
  bit  d1, d2, d3;
  int  mstate;           // 0 waiting first rise, 1 measuring, 2 lost
  int  last_rise;
  int  hi;
  int  div_free;
  int  exp_period, exp_ht, exp_duty;
  bit  exp_mv, exp_lost, exp_dv;
  int  dq_cyc[$];
  int  dq_val[$];

  function automatic int sat(input int x);
    return (x > CMAX) ? CMAX : x;
  endfunction

  task automatic model_step();
    bit r, h;
    e++;
    if (!rst_n) begin
      d1 = 0; d2 = 0; d3 = 0;
      mstate = 0; hi = 0; last_rise = 0; div_free = 0;
      exp_period = 0; exp_ht = 0; exp_duty = 0;
      exp_mv = 0; exp_lost = 0; exp_dv = 0;
      dq_cyc.delete(); dq_val.delete();
      chk_en = 1'b1;
      return;
    end
    r = d2 & ~d3;
    h = d2;
    exp_mv = 0;
    if (r) begin
      if (mstate == 1) begin
        exp_period = sat(e - last_rise);
        exp_ht     = sat(hi);
        exp_mv     = 1;
        if (e >= div_free) begin
          dq_cyc.push_back(e + CNT_W + 8);
          dq_val.push_back(int'((longint'(exp_ht) * 100) / exp_period));
          div_free = e + CNT_W + 8;
        end
      end
      mstate = 1; exp_lost = 0; last_rise = e; hi = 1;
    end else begin
      if (h) hi++;
      if (mstate == 1 && (e - last_rise) == TIMEOUT) begin
        mstate = 2; exp_lost = 1;
      end
    end
    exp_dv = 0;
    if (dq_cyc.size() > 0 && dq_cyc[0] == e) begin
      exp_dv = 1; exp_duty = dq_val[0];
      void'(dq_cyc.pop_front()); void'(dq_val.pop_front());
    end
    d3 = d2; d2 = d1; d1 = f_in;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // ---------------- per-cycle compare ----------------
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk("period",     period,     exp_period);
      chk("high_time",  high_time,  exp_ht);
      chk("meas_valid", meas_valid, exp_mv);
      chk("lost",       lost,       exp_lost);
`ifdef FPM_DUTY_EN
      chk("duty_valid", duty_valid, exp_dv);
      if (exp_dv) chk("duty_pct", duty_pct, exp_duty);
`else
      chk("duty_valid_off", duty_valid, 0);
      chk("duty_pct_off",   duty_pct,   0);
`endif
      if (meas_valid) mv_seen++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input bit v, input int n);
    f_in = v;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int base;
    rst_n = 1'b0;
    f_in  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Regular 2000/500 flashing after an initial low stretch.
    base = mv_seen;
    drive(0, 1000);
    for (int i = 0; i < 4; i++) begin
      drive(1, 2000);
      drive(0, 500);
    end
    chk("lit_strobes_x3", mv_seen - base, 3);
    chk("lit_period_2500", period, 2500);
    chk("lit_high_2000", high_time, 2000);
    chk("lit_lost_0", lost, 0);
`ifdef FPM_DUTY_EN
    chk("lit_duty_80", duty_pct, 80);
`endif

    // Minimum period: toggle every clock.
    for (int i = 0; i < 15; i++) begin
      drive(1, 1);
      drive(0, 1);
    end
    drive(0, 5);
    chk("lit_period_2", period, 2);
    chk("lit_high_1", high_time, 1);

    // Loss while low, then recovery.
    drive(0, 10045);
    chk("lit_lost_low", lost, 1);
    chk("lit_period_hold", period, 2);
`ifdef FPM_DUTY_EN
    chk("lit_duty_50", duty_pct, 50);
`endif
    base = mv_seen;
    drive(1, 100);
    drive(0, 400);
    chk("lit_lost_clear", lost, 0);
    chk("lit_no_strobe_recover", mv_seen - base, 0);
    drive(1, 300);
    chk("lit_period_500", period, 500);
    chk("lit_high_100", high_time, 100);
    drive(0, 200);

    // Reset in the middle of a high phase.
    drive(1, 1200);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("lit_rst_period", period, 0);
    chk("lit_rst_high", high_time, 0);
    chk("lit_rst_lost", lost, 0);
    chk("lit_rst_duty", duty_pct, 0);
    base = mv_seen;
    drive(1, 1300);
    drive(0, 500);
    chk("lit_rst_no_strobe", mv_seen - base, 0);
    drive(1, 500);
    chk("lit_rst_one_strobe", mv_seen - base, 1);
    chk("lit_rst_period_1800", period, 1800);
    chk("lit_rst_high_1300", high_time, 1300);

    // Stuck high until timeout.
    drive(0, 500);
    drive(1, 10050);
    chk("lit_stuck_lost", lost, 1);
    chk("lit_stuck_period", period, 1000);
    chk("lit_stuck_high", high_time, 500);

    // Rise landing exactly on the timeout cycle.
    drive(0, 10);
    drive(1, 50);
    chk("lit_to_lost_clear", lost, 0);
    drive(0, TIMEOUT - 50);
    drive(1, 50);
    chk("lit_to_period", period, TIMEOUT);
    chk("lit_to_high", high_time, 50);
    chk("lit_to_lost", lost, 0);

    // Random flash segments.
    for (int i = 0; i < 60; i++) begin
      drive(1, $urandom_range(1, 150));
      drive(0, $urandom_range(1, 150));
    end
    drive(0, 40);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
